polynomial_finder_lfsr: RTL and testbench

Searches the 32 Lighthouse‑v2 17‑bit LFSR polynomials for the one that links two consecutive decoded sweep words, and reports that polynomial and the LFSR step count between the words. Sits after the bit decoder in the Vive tracker FPGA datapath. Its inputs are two decoded 17‑bit words and their 24‑bit capture timestamps from the 96 MHz timebase. Its result feeds base‑station identification and sweep‑offset computation.

---
 rtl/polynomial_finder_lfsr.sv | 201 ++++++++++++++++++++
 tb/tb_polynomial_finder_lfsr.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/polynomial_finder_lfsr.sv
// rtl/polynomial_finder_lfsr.sv - finds the Lighthouse-v2 LFSR polynomial and step count linking two sweep words
// Optional feature: define POLY_WINDOW_CHECK_EN to accept only matches near the timestamp-derived step count.
module polynomial_finder_lfsr #(
  parameter int          WINDOW   = 32,
  parameter logic [16:0] MAX_ITER = 17'h1FFFF
) (
  input  logic        clk_96MHz,
  input  logic        reset_n,
  input  logic [23:0] ts_last_data,
  input  logic [23:0] ts_last_data1,
  input  logic [16:0] decoded_data,
  input  logic [16:0] decoded_data1,
  input  logic        enable,
  output logic [16:0] polynomial,
  output logic [16:0] iteration_number,
  output logic        ready
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [16:0] NOT_FOUND_ITER = 17'h1FFFF;

  // Tap masks of the 32 Lighthouse-v2 polynomials, index order matters for priority.
  function automatic logic [16:0] poly_rom(input logic [4:0] idx);
    logic [16:0] p;
    case (idx)
      5'd0:  p = 17'h1D258;  5'd1:  p = 17'h17E04;  5'd2:  p = 17'h1FF6B;  5'd3:  p = 17'h13F67;
      5'd4:  p = 17'h1B9EE;  5'd5:  p = 17'h198D1;  5'd6:  p = 17'h178C7;  5'd7:  p = 17'h18A55;
      5'd8:  p = 17'h15777;  5'd9:  p = 17'h1D911;  5'd10: p = 17'h15769;  5'd11: p = 17'h1991F;
      5'd12: p = 17'h12BD0;  5'd13: p = 17'h1CF73;  5'd14: p = 17'h1365D;  5'd15: p = 17'h197F5;
      5'd16: p = 17'h194A0;  5'd17: p = 17'h1B279;  5'd18: p = 17'h13A34;  5'd19: p = 17'h1AE41;
      5'd20: p = 17'h180D4;  5'd21: p = 17'h17891;  5'd22: p = 17'h12E64;  5'd23: p = 17'h17C72;
      5'd24: p = 17'h19C6D;  5'd25: p = 17'h13F32;  5'd26: p = 17'h1AE14;  5'd27: p = 17'h14E76;
      5'd28: p = 17'h13C97;  5'd29: p = 17'h130CB;  5'd30: p = 17'h13750;  default: p = 17'h1CB8D;
    endcase
    return p;
  endfunction

  // Fibonacci step: parity of tapped bits shifts in at the LSB.
  function automatic logic [16:0] lfsr_step(input logic [16:0] s, input logic [16:0] p);
    return {s[15:0], ^(s & p)};
  endfunction

  state_t      state_q, state_d;
  logic [16:0] poly_q, poly_d;
  logic [16:0] iter_q, iter_d;
  logic        ready_q, ready_d;
  logic        load;

  logic [16:0] lfsr_q [32];
  logic [16:0] k_q;
  logic [16:0] target_q;

  // Compare results are registered so the match decision has a full cycle;
  // this is the extra cycle between "compare at step k" and ready rising.
  logic        hit_q;
  logic [16:0] hit_poly_q;
  logic [16:0] hit_k_q;
  logic        last_q;

  logic        match_any;
  logic [4:0]  match_idx;
  logic        win_ok;
  logic        accept;

`ifdef POLY_WINDOW_CHECK_EN
  localparam logic signed [21:0] WIN = 22'(WINDOW);
  logic [23:0]        ts0_q, ts1_q;
  logic [23:0]        ts_diff;
  logic signed [21:0] dist;

  // Expected step count from the latched timestamps, 16 clocks per LFSR bit; wrap handled by 24-bit subtract.
  always_comb begin
    ts_diff = ts1_q - ts0_q;
    dist    = $signed({5'b0, k_q}) - $signed({2'b0, ts_diff[23:4]});
    win_ok  = (dist <= WIN) && (dist >= -WIN);
  end
`else
  assign win_ok = 1'b1;
`endif

  // Lowest-index LFSR equal to the target wins when several match at the same step.
  always_comb begin
    match_any = 1'b0;
    match_idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (lfsr_q[i] == target_q) begin
        match_any = 1'b1;
        match_idx = 5'(i);
      end
    end
    accept = match_any && win_ok;
  end

  // Search datapath: load on start, then step all LFSRs and register each step's compare.
  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) lfsr_q[i] <= '0;
      k_q        <= '0;
      target_q   <= '0;
      hit_q      <= 1'b0;
      hit_poly_q <= '0;
      hit_k_q    <= '0;
      last_q     <= 1'b0;
`ifdef POLY_WINDOW_CHECK_EN
      ts0_q      <= '0;
      ts1_q      <= '0;
`endif
    end else if (load) begin
      for (int i = 0; i < 32; i++) lfsr_q[i] <= decoded_data;
      k_q        <= '0;
      target_q   <= decoded_data1;
      hit_q      <= 1'b0;
      last_q     <= 1'b0;
`ifdef POLY_WINDOW_CHECK_EN
      ts0_q      <= ts_last_data;
      ts1_q      <= ts_last_data1;
`endif
    end else if (state_q == S_SEARCH) begin
      for (int i = 0; i < 32; i++) lfsr_q[i] <= lfsr_step(lfsr_q[i], poly_rom(5'(i)));
      k_q        <= k_q + 17'd1;
      hit_q      <= accept;
      hit_poly_q <= poly_rom(match_idx);
      hit_k_q    <= k_q;
      last_q     <= (k_q == MAX_ITER);
    end
  end

  // Control and result next-state; enable low always wins and clears the result.
  always_comb begin
    state_d = state_q;
    poly_d  = poly_q;
    iter_d  = iter_q;
    ready_d = ready_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_SEARCH;
          load    = 1'b1;
        end
      end
      S_SEARCH: begin
        if (!enable) begin
          state_d = S_IDLE;
          poly_d  = '0;
          iter_d  = '0;
          ready_d = 1'b0;
        end else if (hit_q) begin
          state_d = S_DONE;
          poly_d  = hit_poly_q;
          iter_d  = hit_k_q;
          ready_d = 1'b1;
        end else if (last_q) begin
          state_d = S_DONE;
          poly_d  = '0;
          iter_d  = NOT_FOUND_ITER;
          ready_d = 1'b1;
        end
      end
      S_DONE: begin
        if (!enable) begin
          state_d = S_IDLE;
          poly_d  = '0;
          iter_d  = '0;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        poly_d  = '0;
        iter_d  = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      poly_q  <= '0;
      iter_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      poly_q  <= poly_d;
      iter_q  <= iter_d;
      ready_q <= ready_d;
    end
  end

  assign polynomial       = poly_q;
  assign iteration_number = iter_q;
  assign ready            = ready_q;

endmodule

// File: tb/tb_polynomial_finder_lfsr.sv
// tb/tb_polynomial_finder_lfsr.sv - directed self-checking bench for polynomial_finder_lfsr
module tb_polynomial_finder_lfsr;

  localparam int          WINDOW = 32;
  localparam logic [16:0] MAX_IT = 17'h7A00;

  logic        clk_96MHz = 1'b0;
  logic        reset_n;
  logic [23:0] ts_last_data, ts_last_data1;
  logic [16:0] decoded_data, decoded_data1;
  logic        enable;
  logic [16:0] polynomial, iteration_number;
  logic        ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [16:0] rom [32] = '{
    17'h1D258, 17'h17E04, 17'h1FF6B, 17'h13F67, 17'h1B9EE, 17'h198D1, 17'h178C7, 17'h18A55,
    17'h15777, 17'h1D911, 17'h15769, 17'h1991F, 17'h12BD0, 17'h1CF73, 17'h1365D, 17'h197F5,
    17'h194A0, 17'h1B279, 17'h13A34, 17'h1AE41, 17'h180D4, 17'h17891, 17'h12E64, 17'h17C72,
    17'h19C6D, 17'h13F32, 17'h1AE14, 17'h14E76, 17'h13C97, 17'h130CB, 17'h13750, 17'h1CB8D};

  polynomial_finder_lfsr #(.WINDOW(WINDOW), .MAX_ITER(MAX_IT)) dut (
    .clk_96MHz       (clk_96MHz),
    .reset_n         (reset_n),
    .ts_last_data    (ts_last_data),
    .ts_last_data1   (ts_last_data1),
    .decoded_data    (decoded_data),
    .decoded_data1   (decoded_data1),
    .enable          (enable),
    .polynomial      (polynomial),
    .iteration_number(iteration_number),
    .ready           (ready)
  );

  always #5 clk_96MHz = ~clk_96MHz;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] step(input logic [16:0] s, input logic [16:0] p);
    return {s[15:0], ^(s & p)};
  endfunction

  function automatic logic [16:0] step_n(input logic [16:0] s, input logic [16:0] p, input int n);
    logic [16:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = step(r, p);
    return r;
  endfunction

  // Reference search: first accepted step k, lowest index within that step.
  function automatic void ref_search(input logic [16:0] seed, input logic [16:0] tgt,
                                     input logic [23:0] t0, input logic [23:0] t1,
                                     output logic [16:0] poly, output logic [16:0] iter);
    logic [16:0] s [32];
    logic        ok;
`ifdef POLY_WINDOW_CHECK_EN
    logic [23:0] d;
    int          n;
    d = t1 - t0;
    n = int'(d >> 4);
`endif
    poly = '0;
    iter = 17'h1FFFF;
    for (int i = 0; i < 32; i++) s[i] = seed;
    for (int k = 0; k <= int'(MAX_IT); k++) begin
      ok = 1'b1;
`ifdef POLY_WINDOW_CHECK_EN
      ok = ((k - n) <= WINDOW) && ((n - k) <= WINDOW);
`endif
      if (ok) begin
        for (int i = 0; i < 32; i++) begin
          if (s[i] == tgt) begin
            poly = rom[i];
            iter = 17'(k);
            return;
          end
        end
      end
      for (int i = 0; i < 32; i++) s[i] = step(s[i], rom[i]);
    end
  endfunction

  // Start a search, scramble inputs right after latching, and count cycles until ready.
  task automatic run_search(input logic [16:0] d0, input logic [16:0] d1,
                            input logic [23:0] t0, input logic [23:0] t1,
                            input int budget, output int lat);
    @(negedge clk_96MHz);
    decoded_data  = d0;
    decoded_data1 = d1;
    ts_last_data  = t0;
    ts_last_data1 = t1;
    enable        = 1'b1;
    @(posedge clk_96MHz);
    #1;
    decoded_data  = ~d0;
    decoded_data1 = ~d1;
    ts_last_data  = ~t0;
    ts_last_data1 = ~t1;
    lat = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk_96MHz);
      #1;
      if (ready) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic end_search(input string tag);
    @(negedge clk_96MHz);
    enable = 1'b0;
    @(posedge clk_96MHz);
    #1;
    check_eq({tag, "_rdy_clr"}, 32'(ready), 32'd0);
    check_eq({tag, "_poly_clr"}, 32'(polynomial), 32'd0);
    check_eq({tag, "_iter_clr"}, 32'(iteration_number), 32'd0);
  endtask

  task automatic model_case(input string tag, input logic [16:0] d0, input logic [16:0] d1,
                            input logic [23:0] t0, input logic [23:0] t1, input int budget);
    logic [16:0] ep, ei;
    int          lat, elat;
    ref_search(d0, d1, t0, t1, ep, ei);
    elat = (ep == 17'd0) ? int'(MAX_IT) + 2 : int'(ei) + 2;
    run_search(d0, d1, t0, t1, budget, lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(elat));
    check_eq({tag, "_poly"}, 32'(polynomial), 32'(ep));
    check_eq({tag, "_iter"}, 32'(iteration_number), 32'(ei));
    end_search(tag);
  endtask

  initial begin
    int lat;
    reset_n       = 1'b0;
    enable        = 1'b0;
    decoded_data  = '0;
    decoded_data1 = '0;
    ts_last_data  = '0;
    ts_last_data1 = '0;
    repeat (3) @(posedge clk_96MHz);
    @(negedge clk_96MHz);
    check_eq("rst_rdy", 32'(ready), 32'd0);
    check_eq("rst_poly", 32'(polynomial), 32'd0);
    check_eq("rst_iter", 32'(iteration_number), 32'd0);
    reset_n = 1'b1;

    // Seed equals target: ROM[0] at step 0, ready two cycles after start.
    run_search(17'h12345, 17'h12345, 24'h000100, 24'h000100, 10, lat);
    check_eq("eq_lat", 32'(lat), 32'd2);
    check_eq("eq_poly", 32'(polynomial), 32'h1D258);
    check_eq("eq_iter", 32'(iteration_number), 32'd0);
    repeat (3) @(posedge clk_96MHz);
    #1;
    check_eq("eq_hold_rdy", 32'(ready), 32'd1);
    check_eq("eq_hold_poly", 32'(polynomial), 32'h1D258);
    end_search("eq");

    // 100 steps of ROM[5] from seed 1.
    model_case("s100", 17'h00001, step_n(17'h00001, rom[5], 100), 24'h001000, 24'h001640, 200);

    // Captured sweep pair; expected step count 30203.
    model_case("cap", 17'h149D0, 17'h1C8F9, 24'h9C586A, 24'hA3B827, 32500);

`ifdef POLY_WINDOW_CHECK_EN
    // Real match at step 100, but timestamps put the window at 0..32.
    model_case("win", 17'h00001, step_n(17'h00001, rom[5], 100), 24'hFFFFF0, 24'hFFFFF0,
               int'(MAX_IT) + 10);
`else
    // All-zero seed never leaves zero: not found after MAX_ITER+2 cycles.
    run_search(17'h00000, 17'h00001, 24'h0, 24'h0, int'(MAX_IT) + 10, lat);
    check_eq("nf_lat", 32'(lat), 32'(int'(MAX_IT) + 2));
    check_eq("nf_poly", 32'(polynomial), 32'd0);
    check_eq("nf_iter", 32'(iteration_number), 32'h1FFFF);
    end_search("nf");
`endif

    // Abort an endless search, then run a fresh one with new inputs.
    run_search(17'h00000, 17'h00001, 24'h0, 24'h0, 50, lat);
    check_eq("ab_busy", 32'(ready), 32'd0);
    end_search("ab");
    model_case("ab_new", 17'h0ABCD, step_n(17'h0ABCD, rom[20], 40), 24'hFFFF00, 24'h000180, 200);

    // Asynchronous reset during SEARCH.
    run_search(17'h00000, 17'h00001, 24'h0, 24'h0, 20, lat);
    @(negedge clk_96MHz);
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    check_eq("rs_srch_rdy", 32'(ready), 32'd0);
    check_eq("rs_srch_poly", 32'(polynomial), 32'd0);
    #1 reset_n = 1'b1;

    // Asynchronous reset during DONE, checked before any clock edge.
    run_search(17'h12345, 17'h12345, 24'h0, 24'h0, 10, lat);
    check_eq("rs_done_pre", 32'(ready), 32'd1);
    @(negedge clk_96MHz);
    reset_n = 1'b0;
    #1;
    check_eq("rs_done_rdy", 32'(ready), 32'd0);
    check_eq("rs_done_poly", 32'(polynomial), 32'd0);
    check_eq("rs_done_iter", 32'(iteration_number), 32'd0);
    enable = 1'b0;
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk_96MHz);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
